// File: rtl/ram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ram_ctrl_pkg
// Purpose : Shared definitions for the ram_ctrl block. Holds the default
//           parameter values and the controller state encoding.
// Ports   : none (package)
// Config  : RAM_CTRL_WAIT_EN (used by ram_ctrl.sv) enables the WAIT state.
// ---------------------------------------------------------------------------
package ram_ctrl_pkg;

    localparam int ADDR_WIDTH_DEF  = 16;
    localparam int DATA_WIDTH_DEF  = 16;
    localparam int WAIT_CYCLES_DEF = 4;

    // Controller states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/ram_ctrl_wait_cnt.sv
// ---------------------------------------------------------------------------
// ram_ctrl_wait_cnt
// Purpose : Wait-state down-counter for ram_ctrl. Loaded with a start value,
//           decremented once per cycle while enabled, stops at zero.
// Ports   :
//   clk         in  clock
//   rst_n       in  asynchronous active-low reset
//   load_i      in  load load_val_i into the counter (has priority)
//   load_val_i  in  start value
//   dec_i       in  decrement by one (saturates at zero)
//   zero_o      out counter value is zero
// Config  : only instantiated when RAM_CTRL_WAIT_EN is defined.
// ---------------------------------------------------------------------------
module ram_ctrl_wait_cnt
    import ram_ctrl_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ram_ctrl.sv
// ---------------------------------------------------------------------------
// ram_ctrl
// Purpose : Initiator that drives a single-port synchronous RAM from a
//           valid/ready request port. One request is in flight at a time:
//           IDLE -> ACCESS -> [WAIT x WAIT_CYCLES] -> CAPTURE -> DONE -> IDLE.
// Ports   :
//   clk          in  clock
//   rst_n        in  asynchronous active-low reset
//   req_valid    in  request present
//   req_ready    out high in IDLE; accept = req_valid && req_ready
//   req_wr       in  1 = write, 0 = read
//   req_addr     in  word address
//   req_wdata    in  write data
//   rsp_valid    out one-cycle completion pulse (DONE state)
//   rsp_rdata    out read result, held across writes
//   ram_en       out RAM enable
//   ram_wr_en    out RAM write enable (one cycle per write)
//   ram_addr     out RAM address
//   ram_wr_data  out RAM write data
//   ram_rd_data  in  RAM read data, valid one edge after address sampled
// Config  : define RAM_CTRL_WAIT_EN to add the WAIT state and wait counter
//           (WAIT_CYCLES extra cycles per access). Undefined: fixed
//           four-cycle access, WAIT_CYCLES ignored.
// ---------------------------------------------------------------------------
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  ram_en,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    state_e                state_q;
    state_e                state_d;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  accept;

    assign accept = req_valid && (state_q == ST_IDLE);

`ifdef RAM_CTRL_WAIT_EN
    // Guard the width so WAIT_CYCLES=0 still elaborates a 1-bit counter.
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    // Loading WAIT_CYCLES-1 and leaving on zero gives exactly WAIT_CYCLES
    // cycles in WAIT.
    localparam logic [CNT_W-1:0] LOAD_VAL =
        CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    logic wait_zero;
    logic wait_load;
    logic wait_dec;

    assign wait_load = (state_q == ST_ACCESS);
    assign wait_dec  = (state_q == ST_WAIT);

    ram_ctrl_wait_cnt #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (wait_load),
        .load_val_i (LOAD_VAL),
        .dec_i      (wait_dec),
        .zero_o     (wait_zero)
    );
`endif

    // State register, request latches and response data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wr_q    <= req_wr;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            // RAM output is valid during CAPTURE; writes leave it untouched.
            if ((state_q == ST_CAPTURE) && !wr_q) begin
                rdata_q <= ram_rd_data;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
`ifdef RAM_CTRL_WAIT_EN
                state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_CAPTURE;
`else
                state_d = ST_CAPTURE;
`endif
            end
`ifdef RAM_CTRL_WAIT_EN
            ST_WAIT: begin
                if (wait_zero) begin
                    state_d = ST_CAPTURE;
                end
            end
`endif
            ST_CAPTURE: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs. Reads keep the RAM enabled with a stable address until the
    // data has been captured; writes only touch the RAM in ACCESS.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        ram_en    = 1'b0;
        ram_wr_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
            end
            ST_ACCESS: begin
                ram_en    = 1'b1;
                ram_wr_en = wr_q;
            end
            ST_WAIT, ST_CAPTURE: begin
                ram_en = !wr_q;
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    assign ram_addr    = addr_q;
    assign ram_wr_data = wdata_q;
    assign rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_ram_ctrl.sv
module tb_ram_ctrl;

`ifdef RAM_CTRL_WAIT_EN
    localparam int W = 4;
`else
    localparam int W = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        ram_en;
    logic        ram_wr_en;
    logic [15:0] ram_addr;
    logic [15:0] ram_wr_data;
    logic [15:0] ram_rd_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rsp_cnt = 0;
    int wlog_c[$];
    logic [15:0] wlog_a[$];

    logic [15:0] exp_mem [0:255];
    logic [15:0] exp_rdata;
    logic [15:0] ram_mem [0:255];

    ram_ctrl #(
        .ADDR_WIDTH  (16),
        .DATA_WIDTH  (16),
        .WAIT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .ram_en      (ram_en),
        .ram_wr_en   (ram_wr_en),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM, registered read.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr_en) ram_mem[ram_addr[7:0]] <= ram_wr_data;
            ram_rd_data <= ram_mem[ram_addr[7:0]];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (ram_wr_en) begin
            wlog_a.push_back(ram_addr);
            wlog_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] data);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        chk("ready_before", req_ready, 1);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = data;
        step();
        // ACCESS; scramble inputs to prove they were latched
        req_valid = 1'b0;
        req_wr    = ~wr;
        req_addr  = ~addr;
        req_wdata = ~data;
        chk("acc_ready", req_ready, 0);
        chk("acc_en", ram_en, 1);
        chk("acc_wren", ram_wr_en, wr);
        chk("acc_addr", ram_addr, addr);
        if (wr) chk("acc_wdata", ram_wr_data, data);
        for (int i = 0; i < W; i++) begin
            step();
            chk("wait_en", ram_en, !wr);
            chk("wait_wren", ram_wr_en, 0);
            chk("wait_ready", req_ready, 0);
            chk("wait_rsp", rsp_valid, 0);
            if (!wr) chk("wait_addr", ram_addr, addr);
        end
        step();
        // CAPTURE
        chk("cap_en", ram_en, !wr);
        chk("cap_wren", ram_wr_en, 0);
        chk("cap_ready", req_ready, 0);
        chk("cap_rsp", rsp_valid, 0);
        if (!wr) chk("cap_addr", ram_addr, addr);
        step();
        // DONE
        if (wr) exp_mem[addr[7:0]] = data;
        else    exp_rdata = exp_mem[addr[7:0]];
        chk("done_rsp", rsp_valid, 1);
        chk("done_rdata", rsp_rdata, exp_rdata);
        chk("done_en", ram_en, 0);
        chk("done_ready", req_ready, 0);
        step();
        // IDLE
        chk("idle_ready", req_ready, 1);
        chk("idle_rsp", rsp_valid, 0);
        chk("idle_en", ram_en, 0);
        chk("idle_rdata", rsp_rdata, exp_rdata);
    endtask

    initial begin
        int n;
        int n0;
        int rb;
        for (int i = 0; i < 256; i++) exp_mem[i] = 16'h0000;
        exp_rdata = 16'h0000;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        step();
        step();

        // Reset state
        chk("rst_ready", req_ready, 1);
        chk("rst_en", ram_en, 0);
        chk("rst_wren", ram_wr_en, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wr_data, 0);
        rst_n = 1'b1;

        // 16 writes then 16 reads
        rb = rsp_cnt;
        for (int i = 0; i < 16; i++)
            do_req(1'b1, 16'(i), (i % 2 == 0) ? 16'hAAAA : 16'h5555);
        for (int i = 0; i < 16; i++)
            do_req(1'b0, 16'(i), 16'h0000);
        chk("rsp_count_32", rsp_cnt - rb, 32);

        // Write 1234 to addr 3, read it back
        do_req(1'b1, 16'h0003, 16'h1234);
        do_req(1'b0, 16'h0003, 16'h0000);
        chk("rd_1234", rsp_rdata, 16'h1234);

        // Back-to-back with req_valid held and address changing while busy
        n0 = wlog_a.size();
        rb = rsp_cnt;
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 16'h0040;
        req_wdata = 16'hC000;
        for (int i = 0; i < 3; i++) begin
            chk("b2b_ready_pre", req_ready, 1);
            step();
            exp_mem[8'h40 + i] = 16'hC000 + 16'(i);
            req_addr  = 16'h00F0 + 16'(i);
            req_wdata = 16'hBAD0;
            if (i == 2) req_valid = 1'b0;
            n = 0;
            while (!req_ready && n < 40) begin
                step();
                n++;
            end
            chk("b2b_busy_cycles", n, 3 + W);
            if (i < 2) begin
                req_addr  = 16'h0041 + 16'(i);
                req_wdata = 16'hC001 + 16'(i);
            end
        end
        chk("b2b_wr_pulses", wlog_a.size() - n0, 3);
        chk("b2b_rsp_count", rsp_cnt - rb, 3);
        if (wlog_a.size() >= n0 + 3) begin
            for (int i = 0; i < 3; i++)
                chk("b2b_addr", wlog_a[n0 + i], 16'h0040 + 16'(i));
            chk("b2b_spacing0", wlog_c[n0 + 1] - wlog_c[n0], 4 + W);
            chk("b2b_spacing1", wlog_c[n0 + 2] - wlog_c[n0 + 1], 4 + W);
        end
        do_req(1'b0, 16'h0041, 16'h0000);
        chk("b2b_readback", rsp_rdata, 16'hC001);

        // Reset during ACCESS of a write to addr 5
        rb = rsp_cnt;
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 16'h0005;
        req_wdata = 16'hDEAD;
        step();
        chk("mid_acc_en", ram_en, 1);
        rst_n = 1'b0;
        #1;
        exp_rdata = 16'h0000;
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_en", ram_en, 0);
        chk("mid_rst_wren", ram_wr_en, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        chk("mid_rst_rdata", rsp_rdata, 0);
        chk("mid_rst_addr", ram_addr, 0);
        chk("mid_rst_wdata", ram_wr_data, 0);
        req_valid = 1'b0;
        step();
        step();
        chk("mid_rst_no_rsp", rsp_cnt - rb, 0);
        rst_n = 1'b1;
        // Next request is accepted on the first edge after release;
        // addr 5 must still hold its old value.
        do_req(1'b0, 16'h0005, 16'h0000);
        chk("post_rst_rd5", rsp_rdata, 16'h5555);
        chk("post_rst_rsp_count", rsp_cnt - rb, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, shall set the address width.
REQ-002 Parameter DATA_WIDTH, default 16, shall set the data width.
REQ-003 Parameter WAIT_CYCLES, default 4, shall set the extra wait states per access (used only with RAM_CTRL_WAIT_EN).
REQ-004 Ports shall be, in order:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read result.
- ram_en  out  1  RAM enable.
- ram_wr_en  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wr_data  out  DATA_WIDTH  RAM write data.
- ram_rd_data  in  DATA_WIDTH  RAM read data (registered, valid one edge after the address is sampled).

Function
REQ-005 ram_ctrl shall be the initiator that drives a single-port synchronous RAM (spram) from a valid/ready request port.
REQ-006 States shall be IDLE, ACCESS, WAIT and CAPTURE, DONE.
REQ-007 req_ready shall equal (state==IDLE); a request is accepted on the edge where req_valid && req_ready.
REQ-008 req_wr, req_addr and req_wdata shall be latched on the accept edge; later changes to them shall be ignored until the next accept.
REQ-009 State transitions shall be:
- IDLE->ACCESS on accept.
- ACCESS->WAIT if WAIT_CYCLES>0 and the macro is defined, else ACCESS->CAPTURE.
- WAIT->CAPTURE after exactly WAIT_CYCLES cycles in WAIT.
- CAPTURE->DONE.
- DONE->IDLE unconditionally.
REQ-010 In ACCESS, ram_en=1, ram_wr_en=latched wr, and ram_addr and ram_wr_data come from the latches.
REQ-011 ram_wr_en shall be high only in ACCESS: exactly one cycle per write.
REQ-012 For reads, ram_en shall stay 1 with ram_addr held through WAIT and CAPTURE; for writes, ram_en shall be 0 outside ACCESS.
REQ-013 On the CAPTURE->DONE edge, rsp_rdata shall load ram_rd_data for reads; for writes, rsp_rdata shall hold its previous value.
REQ-014 rsp_valid shall be 1 only in DONE, for exactly one cycle per accepted request, reads and writes alike.
REQ-015 Without wait states, accept at edge k shall give rsp_valid high in the cycle after edge k+2 and req_ready high again after edge k+3 (one access per 4 cycles).
REQ-016 With wait states, each of these figures shall grow by WAIT_CYCLES.
REQ-017 req_valid while busy shall have no effect; a back-to-back request held high shall be accepted the cycle after DONE.
REQ-018 In IDLE, ram_en=0 and ram_wr_en=0.

Reset
REQ-019 rst_n low shall immediately force state=IDLE, ram_en=0, ram_wr_en=0, rsp_valid=0, rsp_rdata=0, ram_addr=0, ram_wr_data=0 and req_ready=1, including mid-access.
REQ-020 An interrupted access shall produce no rsp_valid.
REQ-021 Operation shall resume on the first edge after rst_n deasserts.

Configuration
REQ-022 Macro RAM_CTRL_WAIT_EN defined: the WAIT state and a down-counter of width clog2(WAIT_CYCLES+1) shall be compiled in.
REQ-023 Macro RAM_CTRL_WAIT_EN undefined: the WAIT state and the counter shall be absent, WAIT_CYCLES shall be ignored, and latency shall be fixed per REQ-015.

Structure
REQ-024 Package ram_ctrl_pkg shall hold the state encoding constants (IDLE=0, ACCESS=1, WAIT=2, CAPTURE=3, DONE=4; 3 bits) and the default parameter values.
REQ-025 Sub-module ram_ctrl_wait_cnt (load, decrement, zero flag) shall be instantiated only under RAM_CTRL_WAIT_EN.
REQ-026 No other hierarchy.

Verification
REQ-027 Write 16 words (addr 0..15, data alternating 16'hAAAA/16'h5555), then read back -> each rsp_rdata matches, exactly one rsp_valid per request.
REQ-028 Single read, macro off -> accept at edge k, rsp_valid in the cycle after edge k+2, req_ready low for 3 cycles.
REQ-029 Macro on, WAIT_CYCLES=4 -> rsp_valid in the cycle after edge k+6, ram_wr_en high exactly one cycle on writes.
REQ-030 req_valid held high continuously with changing req_addr -> only addresses present on accept edges are accessed, one access per 4 (or 4+W) cycles.
REQ-031 rst_n pulsed low during ACCESS of a write to addr 5 -> outputs zero immediately, no rsp_valid, next request accepted first edge after release.
REQ-032 Write 16'h1234 to addr 3, then read addr 3 -> rsp_rdata=16'h1234, and rsp_rdata unchanged after the write's rsp_valid.
